// File: rtl/dbus_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// dbus_sram_responder_pkg
// Shared types for the data-bus SRAM responder.
//   msize_t      : request access size (byte / half / word)
//   resp_state_t : responder FSM state encoding
//   is_misaligned: alignment check for a given size and low address bits
// -----------------------------------------------------------------------------
package dbus_sram_responder_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  function automatic logic is_misaligned(input msize_t size, input logic [1:0] addr_lo);
    return ((size == MSIZE4) && (addr_lo != 2'b00)) ||
           ((size == MSIZE2) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/dbus_sram_bank.sv
// -----------------------------------------------------------------------------
// dbus_sram_bank
// DEPTH_WORDS x 32 single-port SRAM with per-byte write enables and a
// registered, write-first read port (a written byte is returned as the new
// value in the same access).
// Ports:
//   clk    in   clock
//   en     in   access enable (read, plus write of enabled bytes)
//   we     in   4 byte write enables
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  registered read data, holds between accesses
// -----------------------------------------------------------------------------
module dbus_sram_bank #(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  // One byte-wide array per lane keeps each lane a plain inferable RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] lane_rdata_reg;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we[gi]) begin
          lane_mem[addr] <= wdata[8*gi +: 8];
          lane_rdata_reg <= wdata[8*gi +: 8];
        end else begin
          lane_rdata_reg <= lane_mem[addr];
        end
      end
    end

    assign rdata[8*gi +: 8] = lane_rdata_reg;
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// -----------------------------------------------------------------------------
// dbus_sram_responder
// Memory-side end of the data bus. Accepts one load/store at a time, performs
// it on an internal word-wide SRAM after LATENCY wait states and returns a
// single-cycle data_ok with the (post-write) word and an error flag.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   req_valid        request present
//   req_addr         byte address
//   req_size         access size (msize_t encoding)
//   req_strobe       byte write enables, 0 = load
//   req_data         store data, lane-replicated by the requester
//   req_addr_ok      request accepted this cycle
//   resp_data_ok     response valid, one cycle per accepted request
//   resp_data        full aligned word (0 on error)
//   resp_err         misaligned or out-of-range, qualifies resp_data_ok
// -----------------------------------------------------------------------------
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [3:0]  req_strobe,
  input  logic [31:0] req_data,
  output logic        req_addr_ok,
  output logic        resp_data_ok,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int          ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT    = 4'(LATENCY);

  resp_state_t state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg;
  msize_t      size_reg;
  logic [3:0]  strobe_reg;
  logic [31:0] data_reg;
  logic        ok_reg;
  logic        err_reg;

  logic        in_idle;
  logic        accept;
  logic        go_resp;
  logic [31:0] cur_addr;
  msize_t      cur_size;
  logic [3:0]  cur_strobe;
  logic [31:0] cur_data;
  logic [31:0] offset;
  logic        cur_err;
  logic        bank_en;
  logic [31:0] bank_rdata;

  assign in_idle     = (state_reg == IDLE);
  assign accept      = in_idle && req_valid && resetn;
  assign req_addr_ok = accept;

  // With LATENCY==0 the SRAM access happens on the accept edge itself, so
  // the live inputs are used while idle and the latched copy otherwise.
  assign cur_addr   = in_idle ? req_addr            : addr_reg;
  assign cur_size   = in_idle ? msize_t'(req_size)  : size_reg;
  assign cur_strobe = in_idle ? req_strobe          : strobe_reg;
  assign cur_data   = in_idle ? req_data            : data_reg;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign offset  = cur_addr - BASE_ADDR;
  assign cur_err = is_misaligned(cur_size, cur_addr[1:0]) || ({1'b0, offset} >= SPAN);

  // Edge that enters RESP: the SRAM is accessed here so its registered read
  // data lines up with resp_data_ok.
  assign go_resp = ((LATENCY == 0) && accept) ||
                   ((state_reg == WAIT) && (cnt_reg == 4'd1));

  // Gating with resetn drops a store whose commit edge coincides with reset.
  assign bank_en = go_resp && resetn && !cur_err;

  dbus_sram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_bank (
    .clk   (clk),
    .en    (bank_en),
    .we    (cur_strobe),
    .addr  (offset[ADDR_W+1:2]),
    .wdata (cur_data),
    .rdata (bank_rdata)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = LAT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      ok_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ok_reg    <= go_resp;
      err_reg   <= go_resp && cur_err;
    end
  end

  // Request latch is pure datapath; it is only consumed after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_reg   <= req_addr;
      size_reg   <= msize_t'(req_size);
      strobe_reg <= req_strobe;
      data_reg   <= req_data;
    end
  end

  assign resp_data_ok = ok_reg;
  assign resp_err     = err_reg;
  assign resp_data    = (ok_reg && !err_reg) ? bank_rdata : 32'h0;

endmodule

// File: tb/tb_dbus_sram_responder.sv
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       resetn;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_addr;
  logic [1:0][1:0]  req_size;
  logic [1:0][3:0]  req_strobe;
  logic [1:0][31:0] req_data;
  logic [1:0]       req_addr_ok;
  logic [1:0]       resp_data_ok;
  logic [1:0][31:0] resp_data;
  logic [1:0]       resp_err;

  // dut0: LATENCY=2, base 0, 4096 words. dut1: LATENCY=0, base 0x1000, 256 words.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int          P_LAT   = (gi == 0) ? 2 : 0;
    localparam int          P_DEPTH = (gi == 0) ? 4096 : 256;
    localparam logic [31:0] P_BASE  = (gi == 0) ? 32'h0 : 32'h1000;
    dbus_sram_responder #(
      .DEPTH_WORDS (P_DEPTH),
      .BASE_ADDR   (P_BASE),
      .LATENCY     (P_LAT)
    ) u_dut (
      .clk          (clk),
      .resetn       (resetn[gi]),
      .req_valid    (req_valid[gi]),
      .req_addr     (req_addr[gi]),
      .req_size     (req_size[gi]),
      .req_strobe   (req_strobe[gi]),
      .req_data     (req_data[gi]),
      .req_addr_ok  (req_addr_ok[gi]),
      .resp_data_ok (resp_data_ok[gi]),
      .resp_data    (resp_data[gi]),
      .resp_err     (resp_err[gi])
    );
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor: every data_ok pops one expected response.
  exp_t mon_e;
  logic mon_have;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (resp_data_ok[d]) begin
        mon_have = 1'b0;
        if (d == 0 && q0.size() > 0) begin
          mon_e = q0.pop_front(); mon_have = 1'b1;
        end else if (d == 1 && q1.size() > 0) begin
          mon_e = q1.pop_front(); mon_have = 1'b1;
        end
        tests_run++;
        if (!mon_have) begin
          tests_failed++;
          $display("FAIL unexpected_resp dut%0d: got data_ok data=%h err=%b at cycle %0d, required no response",
                   d, resp_data[d], resp_err[d], cyc);
        end else if (resp_data[d] !== mon_e.data || resp_err[d] !== mon_e.err || cyc != mon_e.due) begin
          tests_failed++;
          $display("FAIL %s dut%0d: got data=%h err=%b cycle=%0d, required data=%h err=%b cycle=%0d",
                   mon_e.name, d, resp_data[d], resp_err[d], cyc, mon_e.data, mon_e.err, mon_e.due);
        end else begin
          $display("[TB] dut%0d %s: data=%h err=%b cycle=%0d ok", d, mon_e.name, resp_data[d], resp_err[d], cyc);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end else begin
      $display("[TB] %s: %h ok", nm, act);
    end
  endtask

  task automatic issue(input int d, input logic [31:0] a, input logic [1:0] sz,
                       input logic [3:0] sb, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee, input string nm,
                       input bit push, input bit keep, output int t_acc);
    bit   got;
    exp_t e;
    got   = 1'b0;
    t_acc = -1;
    @(posedge clk); #1;
    req_valid[d]  = 1'b1;
    req_addr[d]   = a;
    req_size[d]   = sz;
    req_strobe[d] = sb;
    req_data[d]   = wd;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_addr_ok[d]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout dut%0d %s: got no req_addr_ok in 30 cycles, required accept", d, nm);
      req_valid[d] = 1'b0;
      return;
    end
    t_acc = cyc;
    if (push) begin
      e.data = ed; e.err = ee; e.due = cyc + 1 + lat(d); e.name = nm;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    if (!keep) req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    for (int k = 0; k < 40; k++) begin
      if (qsize(d) == 0) break;
      @(negedge clk);
    end
    if (qsize(d) != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL resp_timeout dut%0d: got %0d responses outstanding, required 0", d, qsize(d));
      if (d == 0) q0.delete(); else q1.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2;
    resetn     = 2'b00;
    req_valid  = 2'b11;
    req_addr   = '0;
    req_size   = '0;
    req_strobe = '0;
    req_data   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_addr_ok_dut%0d", d), 32'(req_addr_ok[d]), 32'h0);
      check($sformatf("reset_data_ok_dut%0d", d), 32'(resp_data_ok[d]), 32'h0);
      check($sformatf("reset_data_dut%0d", d), resp_data[d], 32'h0);
      check($sformatf("reset_err_dut%0d", d), 32'(resp_err[d]), 32'h0);
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    resetn = 2'b11;

    // ---------------- dut0, LATENCY=2 ----------------
    issue(0, 32'h10, 2'd2, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "sw_10", 1, 0, t); drain(0);
    issue(0, 32'h10, 2'd2, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, "lw_10", 1, 0, t); drain(0);
    issue(0, 32'h10, 2'd2, 4'hF, 32'h11223344, 32'h11223344, 1'b0, "sw_10_b", 1, 0, t); drain(0);
    issue(0, 32'h13, 2'd0, 4'h8, 32'h5A5A5A5A, 32'h5A223344, 1'b0, "sb_13", 1, 0, t); drain(0);
    issue(0, 32'h10, 2'd2, 4'h0, 32'h0,        32'h5A223344, 1'b0, "lw_10_after_sb", 1, 0, t); drain(0);
    issue(0, 32'h12, 2'd2, 4'h0, 32'h0,        32'h0,        1'b1, "lw_12_misaligned", 1, 0, t); drain(0);
    issue(0, 32'h11, 2'd1, 4'h6, 32'hFFFFFFFF, 32'h0,        1'b1, "sh_11_misaligned", 1, 0, t); drain(0);
    issue(0, 32'h12, 2'd2, 4'hF, 32'h0,        32'h0,        1'b1, "sw_12_misaligned", 1, 0, t); drain(0);
    issue(0, 32'h10, 2'd2, 4'h0, 32'h0,        32'h5A223344, 1'b0, "lw_10_unchanged", 1, 0, t); drain(0);
    issue(0, 32'h0,    2'd2, 4'hF, 32'h00000001, 32'h00000001, 1'b0, "sw_0", 1, 0, t); drain(0);
    issue(0, 32'h4000, 2'd2, 4'hF, 32'hAAAA5555, 32'h0,        1'b1, "sw_top_oob", 1, 0, t); drain(0);
    issue(0, 32'h3FFC, 2'd2, 4'hF, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, "sw_last_word", 1, 0, t); drain(0);
    issue(0, 32'h0,    2'd2, 4'h0, 32'h0,        32'h00000001, 1'b0, "lw_0_no_wrap", 1, 0, t); drain(0);
    issue(0, 32'h3FFC, 2'd2, 4'h0, 32'h0,        32'h0F0F0F0F, 1'b0, "lw_last_word", 1, 0, t); drain(0);

    // Held req_valid: no accept during WAIT/RESP, next accept at T+LATENCY+2.
    issue(0, 32'h8, 2'd2, 4'hF, 32'h12345678, 32'h12345678, 1'b0, "sw_8_held", 1, 1, t);
    @(negedge clk);
    check("hold_no_accept_in_wait", 32'(req_addr_ok[0]), 32'h0);
    issue(0, 32'h8, 2'd2, 4'h0, 32'h0, 32'h12345678, 1'b0, "lw_8_after_hold", 1, 0, t2);
    check("hold_accept_gap", 32'(t2 - t), 32'd4);
    drain(0);

    // Reset during the wait of a store: store dropped, no response.
    issue(0, 32'h20, 2'd2, 4'hF, 32'h01020304, 32'h01020304, 1'b0, "sw_20", 1, 0, t); drain(0);
    issue(0, 32'h20, 2'd2, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, "sw_20_aborted", 0, 0, t);
    @(posedge clk); #1;
    resetn[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_data_ok", 32'(resp_data_ok[0]), 32'h0);
    check("abort_data", resp_data[0], 32'h0);
    check("abort_err", 32'(resp_err[0]), 32'h0);
    @(posedge clk); #1;
    resetn[0] = 1'b1;
    repeat (5) @(negedge clk);
    issue(0, 32'h20, 2'd2, 4'h0, 32'h0, 32'h01020304, 1'b0, "lw_20_old_value", 1, 0, t); drain(0);

    // ---------------- dut1, LATENCY=0, base 0x1000 ----------------
    issue(1, 32'h1004, 2'd2, 4'hF, 32'h77665544, 32'h77665544, 1'b0, "sw_1004", 1, 0, t); drain(1);
    issue(1, 32'h1000, 2'd2, 4'hF, 32'hA1B2C3D4, 32'hA1B2C3D4, 1'b0, "sw_1000", 1, 0, t); drain(1);
    issue(1, 32'h1004, 2'd2, 4'h0, 32'h0, 32'h77665544, 1'b0, "lw_1004_b2b", 1, 0, t);
    issue(1, 32'h1000, 2'd2, 4'h0, 32'h0, 32'hA1B2C3D4, 1'b0, "lw_1000_b2b", 1, 0, t2);
    check("b2b_accept_gap", 32'(t2 - t), 32'd2);
    drain(1);
    issue(1, 32'h0FFC, 2'd2, 4'h0, 32'h0, 32'h0, 1'b1, "lw_below_base", 1, 0, t); drain(1);
    issue(1, 32'h1400, 2'd2, 4'h0, 32'h0, 32'h0, 1'b1, "lw_above_top", 1, 0, t); drain(1);
    issue(1, 32'h13FC, 2'd2, 4'hF, 32'h00C0FFEE, 32'h00C0FFEE, 1'b0, "sw_13fc", 1, 0, t); drain(1);
    issue(1, 32'h13FC, 2'd2, 4'h0, 32'h0, 32'h00C0FFEE, 1'b0, "lw_13fc", 1, 0, t); drain(1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
